usb_fs_rx_frontend: RTL and testbench

//  Full-speed USB receive front end for the snoop path: samples one D+/D- pair at 4x
//  (48 MHz), recovers bit timing with a DPLL, detects SYNC/EOP, NRZI-decodes and
//  bit-unstuffs, and emits framed bytes. It sits directly upstream of each usbsnoop

---
 rtl/usb_fs_rx_frontend.sv | 238 +++++++++++++++++++++++
 tb/tb_usb_fs_rx_frontend.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_fs_rx_frontend.sv
// Passive full-speed USB receive front end: 4x-oversampled DPLL, SYNC/EOP framing,
// NRZI decode and bit unstuffing. Define USB_RX_PID_CHECK_EN to check the PID byte.
module usb_fs_rx_frontend #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_CYCLES  = 120
) (
  input  logic       clk_48mhz,
  input  logic       reset,
  input  logic       usb_dp_in,
  input  logic       usb_dn_in,
  input  logic       rx_en,
  output logic [1:0] line_state,
  output logic       pkt_start,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       pkt_end,
  output logic       pkt_err,
  output logic       bus_reset
);

  localparam int unsigned CNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [1:0] LS_SE0 = 2'b00;
  localparam logic [1:0] LS_K   = 2'b01;
  localparam logic [1:0] LS_J   = 2'b10;
  localparam logic [1:0] LS_SE1 = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } state_e;

  logic [SYNC_STAGES-1:0] dp_sync_q;
  logic [SYNC_STAGES-1:0] dn_sync_q;
  logic [1:0]             line_d;
  logic [1:0]             line_state_q;
  logic [CNT_W-1:0]       se0_cnt_q;
  logic                   bus_reset_q;
  logic [1:0]             phase_q;
  logic                   jk_change;
  logic                   sample;
  logic                   nrzi_bit;
  state_e                 state_q;
  logic [1:0]             prev_sym_q;
  logic [1:0]             zero_cnt_q;
  logic [2:0]             ones_cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shift_q;
  logic [7:0]             shift_d;
  logic [7:0]             data_q;
  logic                   pkt_start_q;
  logic                   data_valid_q;
  logic                   pkt_end_q;
  logic                   pkt_err_q;
  logic                   resid_err_q;
  logic                   pid_fail;

`ifdef USB_RX_PID_CHECK_EN
  logic first_byte_q;
  logic pid_err_q;
  assign pid_fail = pid_err_q;
`else
  assign pid_fail = 1'b0;
`endif

  assign line_d     = {dp_sync_q[SYNC_STAGES-1], dn_sync_q[SYNC_STAGES-1]};
  assign line_state = line_state_q;
  assign pkt_start  = pkt_start_q;
  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign pkt_end    = pkt_end_q;
  assign pkt_err    = pkt_err_q;
  assign bus_reset  = bus_reset_q;

  // Metastability chain feeding the registered line state
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      dp_sync_q    <= '0;
      dn_sync_q    <= '0;
      line_state_q <= LS_SE0;
    end else begin
      dp_sync_q    <= {dp_sync_q[SYNC_STAGES-2:0], usb_dp_in};
      dn_sync_q    <= {dn_sync_q[SYNC_STAGES-2:0], usb_dn_in};
      line_state_q <= line_d;
    end
  end

  // Bus reset tracks line_state: high from the RST_CYCLES-th consecutive SE0 clock
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      se0_cnt_q   <= '0;
      bus_reset_q <= 1'b0;
    end else if (line_d == LS_SE0) begin
      if (se0_cnt_q != CNT_W'(RST_CYCLES)) begin
        se0_cnt_q <= se0_cnt_q + CNT_W'(1);
      end
      bus_reset_q <= (se0_cnt_q >= CNT_W'(RST_CYCLES - 1));
    end else begin
      se0_cnt_q   <= '0;
      bus_reset_q <= 1'b0;
    end
  end

  // DPLL: phase is 0 on the first clock a new J/K level shows on line_state
  assign jk_change = (line_d[1] ^ line_d[0]) && (line_state_q[1] ^ line_state_q[0])
                     && (line_d != line_state_q);

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      phase_q <= 2'd0;
    end else if (jk_change) begin
      phase_q <= 2'd0;
    end else begin
      phase_q <= phase_q + 2'd1;
    end
  end

  assign sample   = (phase_q == 2'd2);
  assign nrzi_bit = (line_state_q == prev_sym_q);
  assign shift_d  = {nrzi_bit, shift_q[7:1]};

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      prev_sym_q   <= LS_SE0;
      zero_cnt_q   <= 2'd0;
      ones_cnt_q   <= 3'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      data_q       <= 8'd0;
      pkt_start_q  <= 1'b0;
      data_valid_q <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      resid_err_q  <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
      first_byte_q <= 1'b0;
      pid_err_q    <= 1'b0;
`endif
    end else begin
      pkt_start_q  <= 1'b0;
      data_valid_q <= 1'b0;
      pkt_end_q    <= 1'b0;
      pkt_err_q    <= 1'b0;
      if (sample) begin
        prev_sym_q <= line_state_q;
      end
      if (!rx_en) begin
        state_q <= ST_IDLE;
        if (state_q == ST_DATA || state_q == ST_EOP) begin
          pkt_end_q <= 1'b1;
          pkt_err_q <= 1'b1;
        end
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (sample && line_state_q == LS_K && prev_sym_q == LS_J) begin
              state_q    <= ST_SYNC;
              zero_cnt_q <= 2'd1;
            end
          end
          ST_SYNC: begin
            if (sample) begin
              if (line_state_q == LS_SE0 || line_state_q == LS_SE1) begin
                state_q <= ST_IDLE;
              end else if (!nrzi_bit) begin
                if (zero_cnt_q != 2'd3) begin
                  zero_cnt_q <= zero_cnt_q + 2'd1;
                end
              end else if (line_state_q == LS_K && zero_cnt_q == 2'd3) begin
                state_q     <= ST_DATA;
                pkt_start_q <= 1'b1;
                ones_cnt_q  <= 3'd0;
                bit_cnt_q   <= 3'd0;
                resid_err_q <= 1'b0;
`ifdef USB_RX_PID_CHECK_EN
                first_byte_q <= 1'b1;
                pid_err_q    <= 1'b0;
`endif
              end else begin
                state_q <= ST_IDLE;
              end
            end
          end
          ST_DATA: begin
            if (sample) begin
              if (line_state_q == LS_SE0) begin
                state_q     <= ST_EOP;
                resid_err_q <= (bit_cnt_q != 3'd0);
              end else if (line_state_q == LS_SE1) begin
                state_q   <= ST_IDLE;
                pkt_end_q <= 1'b1;
                pkt_err_q <= 1'b1;
              end else if (ones_cnt_q == 3'd6) begin
                // Stuff slot: a 0 is dropped, a 1 is a stuffing violation
                if (nrzi_bit) begin
                  state_q   <= ST_IDLE;
                  pkt_end_q <= 1'b1;
                  pkt_err_q <= 1'b1;
                end else begin
                  ones_cnt_q <= 3'd0;
                end
              end else begin
                shift_q    <= shift_d;
                ones_cnt_q <= nrzi_bit ? ones_cnt_q + 3'd1 : 3'd0;
                bit_cnt_q  <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  data_q       <= shift_d;
                  data_valid_q <= 1'b1;
`ifdef USB_RX_PID_CHECK_EN
                  if (first_byte_q) begin
                    first_byte_q <= 1'b0;
                    pid_err_q    <= (shift_d[7:4] != ~shift_d[3:0]);
                  end
`endif
                end
              end
            end
          end
          ST_EOP: begin
            // A long SE0 closes the packet without waiting for J
            if (bus_reset_q) begin
              state_q   <= ST_IDLE;
              pkt_end_q <= 1'b1;
              pkt_err_q <= 1'b1;
            end else if (sample && line_state_q != LS_SE0) begin
              state_q   <= ST_IDLE;
              pkt_end_q <= 1'b1;
              pkt_err_q <= (line_state_q == LS_J) ? (resid_err_q | pid_fail) : 1'b1;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_fs_rx_frontend.sv
// Bench for usb_fs_rx_frontend: NRZI/stuffing encoder drives packets; an event scoreboard
// built from the payloads plus per-cycle line_state/bus_reset/data models check the DUT.
module tb_usb_fs_rx_frontend;

  localparam int SYNC_STAGES = 2;
  localparam int RST_CYCLES  = 120;
  localparam logic [1:0] SE0 = 2'b00;
  localparam logic [1:0] K   = 2'b01;
  localparam logic [1:0] J   = 2'b10;
`ifdef USB_RX_PID_CHECK_EN
  localparam bit PID_EN = 1'b1;
`else
  localparam bit PID_EN = 1'b0;
`endif

  typedef struct {
    int         kind;   // 0 start, 1 byte, 2 end
    logic [7:0] data;
    logic       err;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dp = 1'b0;
  logic       dn = 1'b0;
  logic       rx_en = 1'b1;
  logic [1:0] line_state;
  logic       pkt_start;
  logic [7:0] data;
  logic       data_valid;
  logic       pkt_end;
  logic       pkt_err;
  logic       bus_reset;

  int         n_checks = 0;
  int         n_pass = 0;
  int         cyc = 0;
  bit         chk_en = 1'b0;
  int         se0_run = 0;
  int         br_hi_cnt = 0;
  int         end_cyc = 0;
  int         mark_cyc = 0;
  int         mark_idx = -1;
  logic [7:0] exp_hold = 8'd0;
  logic [1:0] pin_hist [0:SYNC_STAGES];
  logic [7:0] pay_q [$];
  logic [1:0] sym_q [$];
  ev_t        exp_q [$];

  usb_fs_rx_frontend #(
    .SYNC_STAGES(SYNC_STAGES),
    .RST_CYCLES (RST_CYCLES)
  ) dut (
    .clk_48mhz (clk),
    .reset     (reset),
    .usb_dp_in (dp),
    .usb_dn_in (dn),
    .rx_en     (rx_en),
    .line_state(line_state),
    .pkt_start (pkt_start),
    .data      (data),
    .data_valid(data_valid),
    .pkt_end   (pkt_end),
    .pkt_err   (pkt_err),
    .bus_reset (bus_reset)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
  endtask

  function automatic bit pid_bad(input logic [7:0] b);
    return b[7:4] != ~b[3:0];
  endfunction

  // SYNC, NRZI payload (LSB first, optional stuffing after six ones), then SE0 SE0 J
  task automatic build(input int nbits, input bit stuff_en);
    logic [1:0] cur;
    logic [7:0] byt;
    logic       b;
    int         ones;
    sym_q.delete();
    mark_idx = -1;
    cur = J;
    for (int i = 0; i < 8; i++) begin
      if (i != 7) cur = (cur == J) ? K : J;
      sym_q.push_back(cur);
    end
    ones = 0;
    for (int i = 0; i < nbits; i++) begin
      byt = pay_q[i / 8];
      b = byt[i % 8];
      if (b) begin
        ones++;
        if (ones == 7 && mark_idx < 0) mark_idx = sym_q.size();
      end else begin
        ones = 0;
        cur = (cur == J) ? K : J;
      end
      sym_q.push_back(cur);
      if (stuff_en && ones == 6) begin
        cur = (cur == J) ? K : J;
        sym_q.push_back(cur);
        ones = 0;
      end
    end
    sym_q.push_back(SE0);
    sym_q.push_back(SE0);
    sym_q.push_back(J);
  endtask

  task automatic expect_pkt(input int nbytes, input bit force_err);
    ev_t e;
    e.kind = 0; e.data = 8'd0; e.err = 1'b0;
    exp_q.push_back(e);
    for (int i = 0; i < nbytes; i++) begin
      e.kind = 1; e.data = pay_q[i];
      exp_q.push_back(e);
    end
    e.kind = 2; e.data = 8'd0;
    e.err = force_err | (PID_EN && nbytes > 0 && pid_bad(pay_q[0]));
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit jitter, input int abort_idx);
    for (int i = 0; i < sym_q.size(); i++) begin
      int len;
      len = jitter ? ((i % 2 == 0) ? 3 : 5) : 4;
      @(negedge clk);
      {dp, dn} = sym_q[i];
      if (i == mark_idx) mark_cyc = cyc + 1;
      if (i == abort_idx) rx_en = 1'b0;
      repeat (len - 1) @(negedge clk);
    end
    repeat (16) @(negedge clk);
  endtask

  // Per-cycle compare process
  always begin : mon
    int  npulse;
    int  kind;
    ev_t e;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = SYNC_STAGES; i > 0; i--) pin_hist[i] = pin_hist[i-1];
    pin_hist[0] = {dp, dn};
    if (pin_hist[SYNC_STAGES] == SE0) se0_run++;
    else se0_run = 0;
    if (chk_en) begin
      check("line_state", int'(line_state), int'(pin_hist[SYNC_STAGES]));
      check("bus_reset", int'(bus_reset), (se0_run >= RST_CYCLES) ? 1 : 0);
      if (bus_reset) br_hi_cnt++;
      npulse = int'(pkt_start) + int'(data_valid) + int'(pkt_end);
      check("pulse_exclusive", (npulse <= 1) ? 1 : 0, 1);
      if (npulse != 0) begin
        kind = pkt_start ? 0 : (data_valid ? 1 : 2);
        if (exp_q.size() == 0) begin
          check("unexpected_event", kind, -1);
        end else begin
          e = exp_q.pop_front();
          check("event_kind", kind, e.kind);
          if (e.kind == 1) exp_hold = e.data;
          if (kind == 2) begin
            end_cyc = cyc;
            check("pkt_err", int'(pkt_err), int'(e.err));
          end
        end
      end
      check("data_hold", int'(data), int'(exp_hold));
    end
  end

  initial begin
    int lat;
    int delta;
    repeat (3) @(posedge clk);
    #1;
    check("rst_line_state", int'(line_state), 0);
    check("rst_pkt_start", int'(pkt_start), 0);
    check("rst_data_valid", int'(data_valid), 0);
    check("rst_pkt_end", int'(pkt_end), 0);
    check("rst_bus_reset", int'(bus_reset), 0);
    check("rst_data", int'(data), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    dp = 1'b1; dn = 1'b0;
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (line_state == J) break;
    end
    check("pin_to_line_latency", lat, SYNC_STAGES + 1);
    repeat (6) @(negedge clk);
    chk_en = 1'b1;
    repeat (10) @(negedge clk);

    // ACK handshake
    pay_q = '{8'hD2};
    build(8, 1'b1); expect_pkt(1, 1'b0); drive(1'b0, -1);
    check("drained_ack", exp_q.size(), 0);

    // Stuffed 0xFF then 0x01
    pay_q = '{8'hFF, 8'h01};
    build(16, 1'b1); expect_pkt(2, 1'b0); drive(1'b0, -1);
    check("drained_stuff", exp_q.size(), 0);

    // Missing stuff bit: seventh one aborts
    pay_q = '{8'hFF};
    build(8, 1'b0); expect_pkt(0, 1'b1); drive(1'b0, -1);
    check("drained_stuff_err", exp_q.size(), 0);
    delta = end_cyc - mark_cyc;
    check("stuff_err_within_bit", (delta >= 1 && delta <= SYNC_STAGES + 5) ? 1 : 0, 1);
    pay_q = '{8'hD2};
    build(8, 1'b1); expect_pkt(1, 1'b0); drive(1'b0, -1);
    check("drained_after_err", exp_q.size(), 0);

    // 3/5-clock jittered bit periods
    pay_q = '{8'h5A, 8'hA5};
    build(16, 1'b1); expect_pkt(2, 1'b0); drive(1'b1, -1);
    check("drained_jitter", exp_q.size(), 0);

    // Residual bits before EOP
    pay_q = '{8'hD2, 8'h00};
    build(11, 1'b1); expect_pkt(1, 1'b1); drive(1'b0, -1);
    check("drained_residual", exp_q.size(), 0);

    // 130 clocks of SE0 from idle
    br_hi_cnt = 0;
    @(negedge clk);
    dp = 1'b0; dn = 1'b0;
    repeat (130) @(negedge clk);
    dp = 1'b1; dn = 1'b0;
    repeat (20) @(negedge clk);
    check("bus_reset_high_clocks", br_hi_cnt, 130 - RST_CYCLES + 1);
    check("drained_bus_reset", exp_q.size(), 0);

    // rx_en dropped mid-byte
    pay_q = '{8'h5A};
    build(8, 1'b1); expect_pkt(0, 1'b1); drive(1'b0, 12);
    rx_en = 1'b1;
    repeat (10) @(negedge clk);
    check("drained_rx_en", exp_q.size(), 0);

    // PID that fails its complement check
    pay_q = '{8'hD3};
    build(8, 1'b1); expect_pkt(1, 1'b0); drive(1'b0, -1);
    check("drained_pid", exp_q.size(), 0);
    check("pid_last_byte", int'(data), 8'hD3);

    repeat (10) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
